// File: rtl/scan_mux_pkg.sv
// rtl/scan_mux_pkg.sv - shared state type and channel slice helper for scan_mux
package scan_mux_pkg;

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  // The helper works on a fixed-width bus; callers zero-extend their packed input and
  // truncate the result to their own channel width.
  localparam int unsigned SLICE_BUS_W = 1024;
  localparam int unsigned SLICE_MAX_W = 64;

  function automatic logic [SLICE_MAX_W-1:0] ch_slice(
    input logic [SLICE_BUS_W-1:0] bus,
    input int unsigned            idx,
    input int unsigned            width
  );
    logic [SLICE_BUS_W-1:0] shifted;
    shifted = bus >> (idx * width);
    return shifted[SLICE_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/scan_mux_next.sv
// rtl/scan_mux_next.sv - rotating search for the next enabled channel after ch, with wrap flag
module scan_mux_next #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [SELW-1:0] ch,
  input  logic [N-1:0]    mask,
  output logic [SELW-1:0] nxt,
  output logic            wrap
);

  int              cand;
  logic [SELW-1:0] cidx;
  logic            found;

  // Walk ch+1, ch+2, ... circularly; the first enabled channel wins, otherwise stay on ch.
  always_comb begin
    nxt   = ch;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int i = 1; i < N; i++) begin
      cand = int'(ch) + i;
      if (cand >= N) cand = cand - N;
      cidx = cand[SELW-1:0];
      if (!found && mask[cidx]) begin
        nxt   = cidx;
        found = 1'b1;
      end
    end
    wrap = (nxt < ch);
  end

endmodule

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - N-channel registered mux with manual select and auto-scan (optional SCAN_MUX_MASK_EN)
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  parameter  int DWELL = 3,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               auto_en,
  input  logic               hold,
`ifdef SCAN_MUX_MASK_EN
  input  logic [N-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]   dout,
  output logic [SELW-1:0]    ch,
  output logic               dout_vld,
  output logic               wrap
);

  localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  state_t                 state, state_next;
  logic [CW-1:0]          cnt, cnt_next;
  logic [SELW-1:0]        ch_next, sel_safe, adv_ch;
  logic                   wrap_next, adv_wrap;
  logic [N-1:0]           scan_mask;
  logic [31:0]            sel_wide;
  logic [SLICE_MAX_W-1:0] slice_full;
  logic [WIDTH-1:0]       dout_next;

`ifdef SCAN_MUX_MASK_EN
  assign scan_mask = ch_mask;
`else
  assign scan_mask = '1;
`endif

  // Out-of-range manual selects fall back to channel 0.
  assign sel_wide = 32'(sel);
  assign sel_safe = (sel_wide < 32'(N)) ? sel : '0;

  scan_mux_next #(.N(N)) u_next (
    .ch   (ch),
    .mask (scan_mask),
    .nxt  (adv_ch),
    .wrap (adv_wrap)
  );

  // Next-state decode: manual (or leaving scan) follows sel; scan dwells then advances.
  always_comb begin
    state_next = state;
    ch_next    = ch;
    cnt_next   = '0;
    wrap_next  = 1'b0;
    if (state == ST_MANUAL || !auto_en) begin
      ch_next    = sel_safe;
      state_next = auto_en ? ST_SCAN : ST_MANUAL;
    end else if (cnt == CNT_LAST) begin
      ch_next   = adv_ch;
      wrap_next = adv_wrap;
    end else begin
      cnt_next = cnt + CW'(1);
    end
  end

  assign slice_full = ch_slice(SLICE_BUS_W'(in_data), 32'(ch_next), 32'(WIDTH));
  assign dout_next  = slice_full[WIDTH-1:0];

  // State and output registers; hold freezes everything except the wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_MANUAL;
      ch       <= '0;
      cnt      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      wrap     <= 1'b0;
    end else if (hold) begin
      wrap <= 1'b0;
    end else begin
      state    <= state_next;
      ch       <= ch_next;
      cnt      <= cnt_next;
      dout     <= dout_next;
      dout_vld <= 1'b1;
      wrap     <= wrap_next;
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - self-checking bench for scan_mux (directed plan plus randomized model check)
module tb_scan_mux;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int DW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, auto_en, hold;
  logic [31:0]  in_data;
  logic [1:0]   sel;
  logic [7:0]   dout;
  logic [1:0]   ch;
  logic         vld, wrap;
  logic [23:0]  in3;
  logic [1:0]   sel3;
  logic [7:0]   dout3;
  logic [1:0]   ch3;
  logic         vld3, wrap3;
  logic [7:0]   dout_d1;
  logic [1:0]   ch_d1;
  logic         vld_d1, wrap_d1;
`ifdef SCAN_MUX_MASK_EN
  logic [3:0]   mask;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bit         m_scan;
  int         m_ch, m_age;
  logic [7:0] m_dout;
  logic       m_vld, m_wrap;

  scan_mux #(.N(N), .WIDTH(W), .DWELL(DW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .auto_en(auto_en), .hold(hold),
`ifdef SCAN_MUX_MASK_EN
    .ch_mask(mask),
`endif
    .dout(dout), .ch(ch), .dout_vld(vld), .wrap(wrap)
  );

  scan_mux #(.N(3), .WIDTH(W), .DWELL(DW)) u_n3 (
    .clk(clk), .rst(rst), .in_data(in3), .sel(sel3), .auto_en(auto_en), .hold(hold),
`ifdef SCAN_MUX_MASK_EN
    .ch_mask(mask[2:0]),
`endif
    .dout(dout3), .ch(ch3), .dout_vld(vld3), .wrap(wrap3)
  );

  scan_mux #(.N(N), .WIDTH(W), .DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .auto_en(auto_en), .hold(hold),
`ifdef SCAN_MUX_MASK_EN
    .ch_mask(4'hF),
`endif
    .dout(dout_d1), .ch(ch_d1), .dout_vld(vld_d1), .wrap(wrap_d1)
  );

  function automatic int next_enabled(int cur, logic [3:0] m);
    for (int k = 1; k < N; k++) begin
      if (m[(cur + k) % N]) return (cur + k) % N;
    end
    return cur;
  endfunction

  // Advance the reference model with the inputs present at this edge, then clock once.
  task automatic step();
    logic [3:0] em;
    int         prev, nc;
`ifdef SCAN_MUX_MASK_EN
    em = mask;
`else
    em = 4'hF;
`endif
    if (rst) begin
      m_scan = 0; m_ch = 0; m_age = 0; m_dout = 8'h00; m_vld = 1'b0; m_wrap = 1'b0;
    end else if (hold) begin
      m_wrap = 1'b0;
    end else begin
      prev = m_ch;
      if (!m_scan || !auto_en) begin
        nc     = (int'(sel) < N) ? int'(sel) : 0;
        m_age  = 0;
        m_scan = auto_en;
        m_wrap = 1'b0;
      end else begin
        m_age = m_age + 1;
        if (m_age == DW) begin
          m_age = 0;
          nc    = next_enabled(prev, em);
        end else begin
          nc = prev;
        end
        m_wrap = (nc < prev);
      end
      m_ch   = nc;
      m_dout = in_data[nc*W +: W];
      m_vld  = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_data = 32'h44332211; sel = 2'd1; auto_en = 1'b0; hold = 1'b0; rst = 1'b1;
    in3 = 24'hC0B0A0; sel3 = 2'd1;
`ifdef SCAN_MUX_MASK_EN
    mask = 4'hF;
`endif
    step(); step();
    n_cmp++; if ({dout, ch, vld, wrap} !== 12'h000) begin n_bad++;
      $display("FAIL reset_state dout=%h ch=%0d vld=%b wrap=%b required 00/0/0/0", dout, ch, vld, wrap); end
    rst = 1'b0; sel = 2'd0;
    step();
    n_cmp++; if (dout !== 8'h11 || vld !== 1'b1) begin n_bad++;
      $display("FAIL reset_release dout=%h vld=%b required 11/1", dout, vld); end
  endtask

  task automatic test_manual();
    sel = 2'd2; step();
    n_cmp++; if (dout !== 8'h33 || ch !== 2'd2) begin n_bad++;
      $display("FAIL manual_sel2 dout=%h ch=%0d required 33/2", dout, ch); end
    sel = 2'd1; sel3 = 2'd3; step();
    n_cmp++; if (dout !== 8'h22 || ch !== 2'd1) begin n_bad++;
      $display("FAIL manual_sel1 dout=%h ch=%0d required 22/1", dout, ch); end
    n_cmp++; if (dout3 !== 8'hA0 || ch3 !== 2'd0) begin n_bad++;
      $display("FAIL manual_n3_oob dout=%h ch=%0d required a0/0", dout3, ch3); end
    sel3 = 2'd2; step();
    n_cmp++; if (dout3 !== 8'hC0 || ch3 !== 2'd2) begin n_bad++;
      $display("FAIL manual_n3_sel2 dout=%h ch=%0d required c0/2", dout3, ch3); end
  endtask

  task automatic test_auto_scan();
    logic [1:0] exp_ch;
    logic [7:0] exp_d;
    sel = 2'd0; step();
    auto_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      exp_ch = 2'((i / 3) % 4);
      exp_d  = 8'(8'h11 * (int'(exp_ch) + 1));
      n_cmp++; if (ch !== exp_ch || dout !== exp_d || wrap !== (i == 12)) begin n_bad++;
        $display("FAIL auto_scan[%0d] ch=%0d dout=%h wrap=%b required %0d/%h/%b", i, ch, dout, wrap, exp_ch, exp_d, (i == 12)); end
      n_cmp++; if (ch_d1 !== 2'(i % 4) || wrap_d1 !== (i == 4 || i == 8 || i == 12)) begin n_bad++;
        $display("FAIL dwell1[%0d] ch=%0d wrap=%b required %0d/%b", i, ch_d1, wrap_d1, i % 4, (i == 4 || i == 8 || i == 12)); end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) step();
    hold = 1'b1; in_data[15:8] = 8'h99;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (ch !== 2'd1 || dout !== 8'h22 || wrap !== 1'b0 || vld !== 1'b1) begin n_bad++;
        $display("FAIL hold[%0d] ch=%0d dout=%h wrap=%b vld=%b required 1/22/0/1", i, ch, dout, wrap, vld); end
    end
    hold = 1'b0; step();
    n_cmp++; if (ch !== 2'd1 || dout !== 8'h99) begin n_bad++;
      $display("FAIL hold_release1 ch=%0d dout=%h required 1/99", ch, dout); end
    step();
    n_cmp++; if (ch !== 2'd2 || dout !== 8'h33) begin n_bad++;
      $display("FAIL hold_release2 ch=%0d dout=%h required 2/33", ch, dout); end
    in_data[15:8] = 8'h22;
  endtask

  task automatic test_reset_mid_scan();
    logic [1:0] exp_ch;
    rst = 1'b1; step();
    n_cmp++; if ({dout, ch, vld, wrap} !== 12'h000) begin n_bad++;
      $display("FAIL midscan_reset dout=%h ch=%0d vld=%b wrap=%b required 00/0/0/0", dout, ch, vld, wrap); end
    rst = 1'b0; sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_ch = (i == 3) ? 2'd1 : 2'd0;
      n_cmp++; if (ch !== exp_ch || vld !== 1'b1) begin n_bad++;
        $display("FAIL midscan_resume[%0d] ch=%0d vld=%b required %0d/1", i, ch, vld, exp_ch); end
    end
  endtask

`ifdef SCAN_MUX_MASK_EN
  task automatic test_mask();
    logic [1:0] exp_ch;
    auto_en = 1'b0; sel = 2'd1; mask = 4'b1010; step();
    auto_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_ch = ((i / 3) % 2 == 1) ? 2'd3 : 2'd1;
      n_cmp++; if (ch !== exp_ch || wrap !== (i == 6)) begin n_bad++;
        $display("FAIL mask_1010[%0d] ch=%0d wrap=%b required %0d/%b", i, ch, wrap, exp_ch, (i == 6)); end
    end
    mask = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      step();
      n_cmp++; if (ch !== 2'd3 || wrap !== 1'b0) begin n_bad++;
        $display("FAIL mask_zero[%0d] ch=%0d wrap=%b required 3/0", i, ch, wrap); end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(31) == 0);
      hold    = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) auto_en = ~auto_en;
      sel     = 2'($urandom);
      in_data = $urandom;
`ifdef SCAN_MUX_MASK_EN
      mask    = 4'($urandom);
`endif
      step();
      n_cmp++; if ({dout, ch, vld, wrap} !== {m_dout, 2'(m_ch), m_vld, m_wrap}) begin n_bad++;
        $display("FAIL random[%0d] dout=%h ch=%0d vld=%b wrap=%b required %h/%0d/%b/%b",
                 i, dout, ch, vld, wrap, m_dout, m_ch, m_vld, m_wrap); end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_scan();
    test_hold();
    test_reset_mid_scan();
`ifdef SCAN_MUX_MASK_EN
    test_mask();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog run exceeded time limit");
    $fatal(1);
  end

endmodule
